// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO controller: operation codes, FSM states
// and the wait-cycle timeout limit.
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_MULT = 2'b01,
        WAIT_DIV  = 2'b10
    } state_t;

    localparam int unsigned CNT_W          = 6;
    localparam int unsigned TIMEOUT_CYCLES = 63;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair. A unit commit loads both halves;
// MTHI/MTLO load one half from the write data.
module hilo_regs
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [31:0] commit_hi,
    input  logic [31:0] commit_lo,
    input  logic        mthi_en,
    input  logic        mtlo_en,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Commit only happens in a WAIT state and MTHI/MTLO only in IDLE,
    // so the two never coincide; commit is given priority regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (mthi_en) hi <= wdata;
            if (mtlo_en) lo <= wdata;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: launches multiply/divide units, waits for completion
// with a bounded timeout and commits results into the HI/LO pair.
module hilo_ctrl
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] wdata,
    output logic        mult_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        mult_done,
    output logic        div_start,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        div_done,
    input  logic        div_by_zero,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        timeout_err,
    output logic        dbz_err
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             mult_start_next, div_start_next;
    logic             timeout_next, dbz_next;
    logic             timed_out;
    logic             commit, mthi_en, mtlo_en;
    logic [31:0]      commit_hi, commit_lo;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        mult_start_next = 1'b0;
        div_start_next  = 1'b0;
        timeout_next    = timeout_err;
        dbz_next        = 1'b0;
        commit          = 1'b0;
        commit_hi       = mult_hi;
        commit_lo       = mult_lo;
        mthi_en         = 1'b0;
        mtlo_en         = 1'b0;
        cnt_inc         = cnt + CNT_W'(1);
        timed_out       = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

        case (state)
            IDLE: begin
                if (start) begin
                    case (op_t'(op))
                        OP_MULT: begin
                            state_next      = WAIT_MULT;
                            mult_start_next = 1'b1;
                            cnt_next        = '0;
                        end
                        OP_DIV: begin
                            state_next     = WAIT_DIV;
                            div_start_next = 1'b1;
                            cnt_next       = '0;
                        end
                        OP_MTHI: mthi_en = 1'b1;
                        OP_MTLO: mtlo_en = 1'b1;
                        default: ;
                    endcase
                end
            end
            // done is stale while the launch pulse is still high
            WAIT_MULT: begin
                if (mult_done && !mult_start) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end else if (timed_out) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            WAIT_DIV: begin
                if (div_done && !div_start) begin
                    state_next = IDLE;
                    if (div_by_zero) begin
                        dbz_next = 1'b1;
                    end else begin
                        commit    = 1'b1;
                        commit_hi = div_hi;
                        commit_lo = div_lo;
                    end
                end else if (timed_out) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mult_start  <= 1'b0;
            div_start   <= 1'b0;
            timeout_err <= 1'b0;
            dbz_err     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            mult_start  <= mult_start_next;
            div_start   <= div_start_next;
            timeout_err <= timeout_next;
            dbz_err     <= dbz_next;
        end
    end

    hilo_regs u_regs (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .commit_hi (commit_hi),
        .commit_lo (commit_lo),
        .mthi_en   (mthi_en),
        .mtlo_en   (mtlo_en),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo)
    );

    assign busy    = (state != IDLE);
    assign stall   = busy & (start | rd_req);
    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural multiply/divide units plus an
// architectural HI/LO model, driven by directed cases and random operations.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] wdata = '0;
    logic        mult_start, div_start;
    logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
    logic        mult_done = 1'b0, div_done = 1'b0, div_by_zero = 1'b0;
    logic        rd_req = 1'b0, rd_sel = 1'b0;
    logic [31:0] rd_data, hi, lo;
    logic        busy, stall, timeout_err, dbz_err;

    always #5 clk = ~clk;

    hilo_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .wdata(wdata),
        .mult_start(mult_start), .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_done(mult_done),
        .div_start(div_start), .div_hi(div_hi), .div_lo(div_lo), .div_done(div_done),
        .div_by_zero(div_by_zero), .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .timeout_err(timeout_err), .dbz_err(dbz_err)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] opa = '0, opb = '0;
    int          lat = 1;
    bit          never = 1'b0;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    bit          exp_tmo = 1'b0;

    // Multiplier unit: done is a level, cleared when a new launch is seen.
    int          mcnt = 0;
    logic [63:0] m_p = '0;
    always @(posedge clk) begin
        if (mult_start) begin
            mult_done <= 1'b0;
            mcnt      <= lat;
            m_p       <= $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !never) begin
                mult_done <= 1'b1;
                mult_hi   <= m_p[63:32];
                mult_lo   <= m_p[31:0];
            end
        end
    end

    // Divider unit: garbage on hi/lo when dividing by zero.
    int          dcnt = 0;
    logic [31:0] d_q = '0, d_r = '0;
    logic        d_z = 1'b0;
    always @(posedge clk) begin
        if (div_start) begin
            div_done    <= 1'b0;
            div_by_zero <= 1'b0;
            dcnt        <= lat;
            d_z         <= (opb == 0);
            d_q         <= (opb == 0) ? 32'hDEADBEEF : opa / opb;
            d_r         <= (opb == 0) ? 32'hDEADBEEF : opa % opb;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !never) begin
                div_done    <= 1'b1;
                div_by_zero <= d_z;
                div_lo      <= d_q;
                div_hi      <= d_r;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One full operation through the controller, compared with the model.
    task automatic run_op(input logic [1:0] o, input logic [31:0] wd, input bit rd_hold);
        int     busy_cyc, pulse_cyc, wrong_cyc, dbz_cyc, free_rd, exp_busy;
        longint pr;
        bit     exp_dbz;
        busy_cyc = 0; pulse_cyc = 0; wrong_cyc = 0; dbz_cyc = 0; free_rd = 0;
        exp_dbz = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; wdata = wd; rd_req = rd_hold; rd_sel = 1'b1;
        #1;
        check("accept_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (o == OP_MTHI || o == OP_MTLO) begin
            if (o == OP_MTHI) exp_hi = wd;
            else              exp_lo = wd;
            check("mt_hi", hi, exp_hi);
            check("mt_lo", lo, exp_lo);
            rd_req = 1'b0;
            return;
        end
        exp_busy = never ? int'(TIMEOUT_CYCLES) : lat + 2;
        if (never) begin
            exp_tmo = 1'b1;
        end else if (o == OP_MULT) begin
            pr = longint'(signed'(opa)) * longint'(signed'(opb));
            exp_hi = pr[63:32];
            exp_lo = pr[31:0];
        end else if (opb == 0) begin
            exp_dbz = 1'b1;
        end else begin
            exp_lo = opa / opb;
            exp_hi = opa % opb;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            pulse_cyc += int'(o == OP_MULT ? mult_start : div_start);
            wrong_cyc += int'(o == OP_MULT ? div_start : mult_start);
            dbz_cyc   += int'(dbz_err);
            if (rd_hold && !stall) free_rd++;
        end
        dbz_cyc += int'(dbz_err);
        if (rd_hold) begin
            check("rd_stall_busy", 32'(free_rd), 32'd0);
            check("rd_stall_end", 32'(stall), 32'd0);
            check("rd_data_hi", rd_data, exp_hi);
        end
        rd_req = 1'b0;
        @(negedge clk);
        dbz_cyc += int'(dbz_err);
        check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
        check("launch_pulse", 32'(pulse_cyc), 32'd1);
        check("other_pulse", 32'(wrong_cyc), 32'd0);
        check("dbz_pulses", 32'(dbz_cyc), 32'(exp_dbz));
        check("timeout_err", 32'(timeout_err), 32'(exp_tmo));
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
    endtask

    initial begin
        int found;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {28'd0, mult_start, div_start, timeout_err, dbz_err}, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // MTHI with a same-cycle read returns the old value
        run_op(OP_MTHI, 32'hCAFEF00D, 1'b0);
        run_op(OP_MTLO, 32'h0BADC0DE, 1'b0);
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; wdata = 32'h11112222; rd_req = 1'b1; rd_sel = 1'b1;
        #1;
        check("mthi_rd_old", rd_data, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_hi = 32'h11112222;
        check("mthi_rd_new", rd_data, 32'h11112222);
        rd_sel = 1'b0;
        #1;
        check("rd_lo", rd_data, 32'h0BADC0DE);
        rd_req = 1'b0;

        // 7 * -3 with a 32-cycle multiplier
        opa = 32'd7; opb = 32'hFFFFFFFD; lat = 32; never = 1'b0;
        run_op(OP_MULT, '0, 1'b0);
        check("mult_k_hi", hi, 32'hFFFFFFFF);
        check("mult_k_lo", lo, 32'hFFFFFFEB);

        // 100 / 7, then a second DIV requested in the commit cycle
        opa = 32'd100; opb = 32'd7; lat = 5;
        @(negedge clk);
        start = 1'b1; op = OP_DIV;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && div_done && !div_start) begin
                found = 1;
                break;
            end
        end
        check("b2b_commit_seen", 32'(found), 32'd1);
        opa = 32'd50; opb = 32'd9;
        start = 1'b1; op = OP_DIV;
        #1;
        check("b2b_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_nostall", 32'(stall), 32'd0);
        check("div_k_lo", lo, 32'h0000000E);
        check("div_k_hi", hi, 32'h00000002);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_launch", 32'(div_start), 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("b2b_lo", lo, 32'd5);
        check("b2b_hi", hi, 32'd5);
        exp_lo = 32'd5; exp_hi = 32'd5;

        // divide by zero leaves HI/LO alone
        run_op(OP_MTHI, 32'h12345678, 1'b0);
        run_op(OP_MTLO, 32'h12345678, 1'b0);
        opa = 32'd55; opb = 32'd0; lat = 4;
        run_op(OP_DIV, '0, 1'b0);
        check("dbz_hi", hi, 32'h12345678);
        check("dbz_lo", lo, 32'h12345678);

        // read of HI held through a multiply
        opa = $urandom; opb = $urandom; lat = 10;
        run_op(OP_MULT, '0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            logic [1:0] ro;
            ro  = 2'($urandom_range(0, 3));
            opa = $urandom;
            opb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            lat = $urandom_range(1, 40);
            run_op(ro, $urandom, 1'($urandom_range(0, 1)));
        end

        // multiplier that never finishes
        run_op(OP_MTHI, 32'h600DF00D, 1'b0);
        never = 1'b1; lat = 5;
        run_op(OP_MULT, '0, 1'b0);
        check("tmo_hi", hi, 32'h600DF00D);
        never = 1'b0; opa = 32'd3; opb = 32'd4; lat = 3;
        run_op(OP_MULT, '0, 1'b0);

        // reset in the middle of a divide, then a late done
        run_op(OP_MTHI, 32'hA5A5A5A5, 1'b0);
        opa = 32'd1000; opb = 32'd3; lat = 20;
        @(negedge clk);
        start = 1'b1; op = OP_DIV;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_flags", {30'd0, timeout_err, div_start}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("late_done_seen", 32'(div_done), 32'd1);
        check("late_busy", 32'(busy), 32'd0);
        check("late_hi", hi, 32'd0);
        check("late_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  one-cycle operation request.
REQ-004 SHALL have port: op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO; sampled with start.
REQ-005 SHALL have port: wdata  in  32  MTHI/MTLO write data.
REQ-006 SHALL have port: mult_start  out  1  registered one-cycle launch pulse to multiplier.
REQ-007 SHALL have ports: mult_hi, mult_lo  in  32 each; mult_done  in  1 (level, cleared by multiplier on launch).
REQ-008 SHALL have port: div_start  out  1  registered one-cycle launch pulse to divider.
REQ-009 SHALL have ports: div_hi (remainder), div_lo (quotient)  in  32 each; div_done  in  1 (level); div_by_zero  in  1.
REQ-010 SHALL have ports: rd_req  in  1; rd_sel  in  1 (0 LO, 1 HI); rd_data  out  32.
REQ-011 SHALL have ports: hi, lo  out  32 each; busy  out  1; stall  out  1.
REQ-012 SHALL have ports: timeout_err  out  1 (sticky); dbz_err  out  1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_MULT, WAIT_DIV; busy = (state != IDLE).
REQ-014 SHALL, in IDLE with start and op=MULT, move to WAIT_MULT and drive mult_start high for exactly the next cycle.
REQ-015 SHALL, in IDLE with start and op=DIV, move to WAIT_DIV and drive div_start high for exactly the next cycle.
REQ-016 SHALL, in IDLE with start and op=MTHI/MTLO, write wdata to hi/lo at that edge; the state remains IDLE.
REQ-017 SHALL ignore mult_done/div_done in any cycle where the matching start pulse is high, because stale done from the previous op is still visible.
REQ-018 SHALL, in WAIT_x with done=1 (start pulse low), load hi<=x_hi and lo<=x_lo and return to IDLE at the same edge; the new value is visible the next cycle.
REQ-019 SHALL, on DIV completion with div_by_zero=1, leave hi/lo unchanged, pulse dbz_err for one cycle, and return to IDLE.
REQ-020 SHALL count WAIT cycles in a 6-bit counter cleared on launch. At count 63 without done, it SHALL set timeout_err (sticky until reset), leave hi/lo unchanged, and return to IDLE.
REQ-021 SHALL drive stall = busy & (start | rd_req); start while busy is not accepted, and the requester holds start.
REQ-022 SHALL drive rd_data = rd_sel ? hi : lo combinationally from registers; it is valid only when stall=0.
REQ-023 SHALL treat done plus start in the commit cycle as stalled; the new start is accepted in the following IDLE cycle.
REQ-024 SHALL, on a same-cycle MTHI/MTLO and rd_req in IDLE, return the pre-write value.

Reset
REQ-025 SHALL, on reset (any time, including mid-WAIT), force IDLE, hi=lo=0, counter=0, and mult_start=div_start=timeout_err=dbz_err=0 immediately.
REQ-026 SHALL not commit a late done arriving after reset release unless a new op was launched.

Structure
REQ-027 SHALL take op encodings, FSM state encodings, and TIMEOUT_CYCLES=63 from a shared package hilo_pkg.
REQ-028 SHALL place the HI/LO register pair with its write muxing (commit/MTHI/MTLO/reset) in sub-module hilo_regs; the FSM, counter, and pulses stay in hilo_ctrl.

Verification
REQ-029 SHALL cover: MULT A=7, B=-3 with a 32-cycle multiplier model -> mult_start 1 cycle, busy ~33 cycles, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-030 SHALL cover: DIV 100/7 -> lo=0000000E, hi=00000002; back-to-back second DIV on the commit cycle -> stalled 1 cycle, then launched.
REQ-031 SHALL cover: DIV with div_by_zero=1 at done, prior hi=lo=12345678 -> unchanged, dbz_err one-cycle pulse.
REQ-032 SHALL cover: MULT with mult_done never asserted -> timeout_err set after 63 WAIT cycles, IDLE, hi/lo unchanged.
REQ-033 SHALL cover: rd_req rd_sel=1 during WAIT_MULT -> stall=1 until commit, then rd_data = new hi.
REQ-034 SHALL cover: reset asserted 10 cycles into WAIT_DIV, then stale div_done=1 -> IDLE, hi=lo=0, no commit.
